// File: rtl/ethpipe_csr_dma.sv
// ethpipe_csr_dma: BAR0 control/status register file for the ethpipe receive DMA channels.
//
// Holds the free-running 64-bit global counter, a tear-free snapshot of it, the DMA control
// and ring length registers, per-channel start addresses, and per-channel interrupt pending/mask
// state that drives a level interrupt towards the PCIe core.
//
// Ports:
//   clk_125, sys_rst        clock and synchronous active-high reset
//   slv_ce_i/we_i/adr_i     slave access strobe (already BAR0 qualified), direction, word address
//   slv_dat_i, slv_sel_i    write data and byte enables ([1] -> [15:8], [0] -> [7:0])
//   slv_dat_o               registered read data, held between reads
//   global_counter          free-running timestamp
//   dma_enable, dma_length  DMA control bit 0 and ring length in dwords
//   dma_addr_start          per-channel start address [31:2], channel n at [30n+29:30n]
//   dma_addr_cur            per-channel current address [31:2], same packing
//   ch_intr_i               per-channel one-cycle interrupt request pulses
//   sys_intr                registered level interrupt
//
// Bus words are byte-swapped: a 16-bit chunk c of a register reads back as {c[7:0], c[15:8]}.

module ethpipe_csr_dma #(
  parameter int unsigned CHANNELS    = 2,
  parameter logic [21:0] LEN_RST     = 22'h01_0000,
  parameter logic [31:0] ADDR_RST    = 32'h1000_0000,
  parameter logic [31:0] ADDR_STRIDE = 32'h0010_0000
) (
  input  logic                   clk_125,
  input  logic                   sys_rst,
  input  logic                   slv_ce_i,
  input  logic                   slv_we_i,
  input  logic [11:1]            slv_adr_i,
  input  logic [15:0]            slv_dat_i,
  input  logic [1:0]             slv_sel_i,
  output logic [15:0]            slv_dat_o,
  output logic [63:0]            global_counter,
  output logic                   dma_enable,
  output logic [21:2]            dma_length,
  output logic [CHANNELS*30-1:0] dma_addr_start,
  input  logic [CHANNELS*30-1:0] dma_addr_cur,
  input  logic [CHANNELS-1:0]    ch_intr_i,
  output logic                   sys_intr
);

  localparam logic [3:0] NumCh = 4'(CHANNELS);

  logic [63:0]               cnt_q;
  logic [63:16]              snap_q;   // low 16 bits are never read back from the snapshot
  logic [6:0]                ctrl_q;   // dma_ctrl bits {7:4, 2:0}; bit 3 is derived on read
  logic [CHANNELS-1:0]       pend_q;
  logic [CHANNELS-1:0]       mask_q;
  logic [CHANNELS-1:0]       pend_clr;
  logic [21:2]               len_q;
  logic [CHANNELS-1:0][29:0] start_q;
  logic [7:0][29:0]          start_pad;
  logic [7:0][29:0]          cur_pad;
  logic [15:0]               dat_q;
  logic [15:0]               rdata;
  logic                      intr_q;
  logic                      intr_any;

  logic       hit;
  logic       rd;
  logic       wr;
  logic [5:0] wadr;
  logic       ch_sel;
  logic [3:0] ch_idx;
  logic [1:0] ch_reg;
  logic       ch_ok;

  function automatic logic [15:0] swap(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [29:0] addr_rst(input int unsigned n);
    return 30'((ADDR_RST + ADDR_STRIDE * n) >> 2);
  endfunction

  assign hit    = (slv_adr_i[11:7] == 5'd0);
  assign wadr   = slv_adr_i[6:1];
  assign rd     = slv_ce_i & ~slv_we_i;
  assign wr     = slv_ce_i & slv_we_i & hit;
  // Word addresses 0x10 and above form four-word channel blocks.
  assign ch_sel = (wadr[5:4] != 2'b00);
  assign ch_idx = wadr[5:2] - 4'd4;
  assign ch_reg = wadr[1:0];
  assign ch_ok  = ch_sel && (ch_idx < NumCh);

  assign intr_any = |(pend_q & mask_q);

  assign pend_clr = (wr && (wadr == 6'h09) && slv_sel_i[1]) ? slv_dat_i[8 +: CHANNELS] : '0;

  // Pad channel arrays to the maximum of 8 so the read mux can index with a fixed width.
  always_comb begin
    start_pad = '0;
    cur_pad   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      start_pad[i] = start_q[i];
      cur_pad[i]   = dma_addr_cur[30*i +: 30];
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      if (ch_sel) begin
        if (ch_ok) begin
          case (ch_reg)
            2'd0:    rdata = swap({start_pad[ch_idx[2:0]][13:0], 2'b00});
            2'd1:    rdata = swap(start_pad[ch_idx[2:0]][29:14]);
            2'd2:    rdata = swap({cur_pad[ch_idx[2:0]][13:0], 2'b00});
            default: rdata = swap(cur_pad[ch_idx[2:0]][29:14]);
          endcase
        end
      end else begin
        case (wadr)
          6'h02:   rdata = swap(cnt_q[15:0]);
          6'h03:   rdata = swap(snap_q[31:16]);
          6'h04:   rdata = swap(snap_q[47:32]);
          6'h05:   rdata = swap(snap_q[63:48]);
          6'h08:   rdata = {ctrl_q[6:3], intr_any, ctrl_q[2:0], 8'h00};
          6'h09:   rdata = {8'(pend_q), 8'h00};
          6'h0A:   rdata = swap({len_q[15:2], 2'b00});
          6'h0B:   rdata = {2'b00, len_q[21:16], 8'h00};
          6'h0C:   rdata = {8'(mask_q), 8'h00};
          default: rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      snap_q <= '0;
      ctrl_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      len_q  <= LEN_RST[21:2];
      dat_q  <= '0;
      intr_q <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        start_q[i] <= addr_rst(i);
      end
    end else begin
      cnt_q  <= cnt_q + 64'd1;
      intr_q <= ctrl_q[0] & intr_any;
      // A new request in the same cycle as a clear keeps the bit set.
      pend_q <= (pend_q & ~pend_clr) | ch_intr_i;

      if (rd) begin
        dat_q <= rdata;
        // Capture the pre-increment value so the upper words match the live word returned now.
        if (hit && (wadr == 6'h02)) begin
          snap_q <= cnt_q[63:16];
        end
      end

      if (wr && !ch_sel) begin
        case (wadr)
          6'h08: if (slv_sel_i[1]) ctrl_q <= {slv_dat_i[15:12], slv_dat_i[10:8]};
          6'h0A: begin
            if (slv_sel_i[1]) len_q[7:2]  <= slv_dat_i[15:10];
            if (slv_sel_i[0]) len_q[15:8] <= slv_dat_i[7:0];
          end
          6'h0B: if (slv_sel_i[1]) len_q[21:16] <= slv_dat_i[13:8];
          6'h0C: if (slv_sel_i[1]) mask_q <= slv_dat_i[8 +: CHANNELS];
          default: ;
        endcase
      end

      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr && ch_ok && (ch_idx == 4'(i))) begin
          if (ch_reg == 2'd0) begin
            if (slv_sel_i[1]) start_q[i][5:0]  <= slv_dat_i[15:10];
            if (slv_sel_i[0]) start_q[i][13:6] <= slv_dat_i[7:0];
          end else if (ch_reg == 2'd1) begin
            if (slv_sel_i[1]) start_q[i][21:14] <= slv_dat_i[15:8];
            if (slv_sel_i[0]) start_q[i][29:22] <= slv_dat_i[7:0];
          end
        end
      end
    end
  end

  assign slv_dat_o      = dat_q;
  assign global_counter = cnt_q;
  assign dma_enable     = ctrl_q[0];
  assign dma_length     = len_q;
  assign dma_addr_start = start_q;
  assign sys_intr       = intr_q;

endmodule
